// File: rtl/nr_divider_seq.sv
// Sequential radix-2 non-restoring unsigned divider, one quotient bit per cycle.
// Valid/ready handshake on both the operand side and the result side.
module nr_divider_seq #(
  parameter int N = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_zero
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic [N:0]     r_q, r_d;
  logic [N-1:0]   q_q, q_d;
  logic [N-1:0]   d_q, d_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           dz_q, dz_d;
  logic [N-1:0]   quot_q, quot_d;
  logic [N-1:0]   rem_q, rem_d;
  logic           dzo_q, dzo_d;

  logic [N:0]     r_shift;
  logic [N:0]     alu_a;
  logic [N:0]     alu_b;
  logic           alu_sub;
  logic [N:0]     alu_sum;

  // One shared (N+1)-bit adder-subtractor: RUN uses the shifted remainder,
  // FIX reuses it unshifted for the final restore (always an add).
  always_comb begin
    r_shift = {r_q[N-1:0], q_q[N-1]};
    alu_a   = (state_q == S_FIX) ? r_q : r_shift;
    alu_sub = (state_q == S_RUN) && !r_q[N];
    alu_b   = alu_sub ? ~{1'b0, d_q} : {1'b0, d_q};
    alu_sum = alu_a + alu_b + {{N{1'b0}}, alu_sub};
  end

  // NOTE: every variable gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    dz_d    = dz_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dzo_d   = dzo_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          r_d     = '0;
          q_d     = dividend;
          d_d     = divisor;
          dz_d    = (divisor == '0);
          cnt_d   = CW'(N - 1);
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        r_d = alu_sum;
        q_d = {q_q[N-2:0], ~alu_sum[N]};
        if (cnt_q == '0) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_FIX: begin
        r_d     = r_q[N] ? alu_sum : r_q;
        quot_d  = q_q;
        rem_d   = r_q[N] ? alu_sum[N-1:0] : r_q[N-1:0];
        dzo_d   = dz_q;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      dz_q    <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dzo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      dz_q    <= dz_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dzo_q   <= dzo_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign div_zero  = dzo_q;

endmodule

// File: tb/tb_nr_divider_seq.sv
// Directed and scoreboard-driven bench for nr_divider_seq at N=24.
module tb_nr_divider_seq;

  localparam int N = 24;
  localparam logic [N-1:0] ALL1 = {N{1'b1}};

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_zero;

  int total = 0;
  int bad   = 0;

  nr_divider_seq #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents one operand pair for a single edge; returns #1 after the accepting edge.
  task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
  endtask

  // Counts edges until out_valid (bounded); flags any in_ready seen while busy.
  task automatic wait_result(output int cyc, output bit ready_leak);
    cyc = 0;
    ready_leak = 1'b0;
    while (!out_valid && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
      if (in_ready) ready_leak = 1'b1;
    end
  endtask

  task automatic pop_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
    total++;
    if (quotient !== '0 || remainder !== '0 || div_zero !== 1'b0) begin
      bad++;
      $display("FAIL reset_data: q=%h r=%h dz=%b want 0/0/0", quotient, remainder, div_zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic run_vector(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                            input logic [N-1:0] eq, input logic [N-1:0] er, input logic edz);
    int cyc;
    bit leak;
    start_op(a, b);
    wait_result(cyc, leak);
    total++;
    if (cyc !== N + 1 || leak !== 1'b0) begin
      bad++;
      $display("FAIL %s_latency: cycles=%0d ready_leak=%b want %0d/0", name, cyc, leak, N + 1);
    end
    total++;
    if (quotient !== eq || remainder !== er || div_zero !== edz) begin
      bad++;
      $display("FAIL %s_data: q=%h r=%h dz=%b want %h/%h/%b", name, quotient, remainder,
               div_zero, eq, er, edz);
    end
    pop_result();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s_release: out_valid=%b in_ready=%b want 0/1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_basic();
    run_vector("basic", 24'd100, 24'd7, 24'd14, 24'd2, 1'b0);
  endtask

  task automatic test_extremes();
    run_vector("max_by_1", ALL1, 24'd1, ALL1, 24'd0, 1'b0);
    run_vector("small_by_big", 24'd5, 24'd9, 24'd0, 24'd5, 1'b0);
    run_vector("max_by_max", ALL1, ALL1, 24'd1, 24'd0, 1'b0);
  endtask

  task automatic test_div_zero();
    run_vector("div_zero", 24'd1234, 24'd0, ALL1, 24'd1234, 1'b1);
  endtask

  task automatic test_backpressure();
    int cyc;
    bit leak;
    bit unstable;
    start_op(24'd200, 24'd9);
    wait_result(cyc, leak);
    total++;
    if (cyc !== N + 1) begin
      bad++;
      $display("FAIL bp_latency: cycles=%0d want %0d", cyc, N + 1);
    end
    // Operands offered while busy must be ignored.
    @(negedge clk);
    in_valid = 1'b1;
    dividend = 24'd77;
    divisor  = 24'd1;
    unstable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== 24'd22 ||
          remainder !== 24'd2 || div_zero !== 1'b0) unstable = 1'b1;
    end
    total++;
    if (unstable) begin
      bad++;
      $display("FAIL bp_hold: out_valid=%b in_ready=%b q=%0d r=%0d want 1/0/22/2",
               out_valid, in_ready, quotient, remainder);
    end
    @(negedge clk);
    in_valid = 1'b0;
    pop_result();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    start_op(24'd1000, 24'd3);
    repeat (12) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || quotient !== '0 ||
        remainder !== '0 || div_zero !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid: in_ready=%b out_valid=%b q=%h r=%h dz=%b want 1/0/0/0/0",
               in_ready, out_valid, quotient, remainder, div_zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_vector("after_reset", 24'd1000, 24'd3, 24'd333, 24'd1, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] exp_q[$];
    logic [N-1:0] exp_r[$];
    logic         exp_dz[$];
    logic [N-1:0] eq, er;
    logic         edz;
    int accepted = 0;
    int results  = 0;
    int cyc      = 0;
    localparam int NUM = 16;

    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    dividend  = $urandom;
    divisor   = $urandom_range(1, 4095);
    while (results < NUM && cyc < 2000) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL b2b_extra: unexpected result q=%h r=%h", quotient, remainder);
        end else begin
          eq = exp_q.pop_front();
          er = exp_r.pop_front();
          edz = exp_dz.pop_front();
          total++;
          if (quotient !== eq || remainder !== er || div_zero !== edz) begin
            bad++;
            $display("FAIL b2b_data[%0d]: q=%h r=%h dz=%b want %h/%h/%b", results,
                     quotient, remainder, div_zero, eq, er, edz);
          end
        end
        results++;
      end
      if (in_valid && in_ready) begin
        if (divisor == '0) begin
          exp_q.push_back(ALL1);
          exp_r.push_back(dividend);
          exp_dz.push_back(1'b1);
        end else begin
          exp_q.push_back(dividend / divisor);
          exp_r.push_back(dividend % divisor);
          exp_dz.push_back(1'b0);
        end
        accepted++;
        @(negedge clk);
        dividend = $urandom;
        case (accepted % 4)
          0: divisor = $urandom;
          1: divisor = $urandom_range(1, 255);
          2: divisor = (accepted == 6) ? '0 : $urandom_range(1, 65535);
          default: divisor = dividend >> $urandom_range(0, 8);
        endcase
        if (accepted >= NUM) in_valid = 1'b0;
      end else begin
        @(negedge clk);
      end
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    total++;
    if (results !== NUM || accepted !== NUM || exp_q.size() !== 0) begin
      bad++;
      $display("FAIL b2b_count: results=%0d accepted=%0d pending=%0d want %0d/%0d/0",
               results, accepted, exp_q.size(), NUM, NUM);
    end
  endtask

  initial begin
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    test_reset();
    test_basic();
    test_extremes();
    test_div_zero();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
